guess_controller: RTL and testbench

GUESS_CONTROLLER -- requirements
Module: guess_controller

---
 rtl/guess_pkg.sv | 20 ++
 rtl/guess_cmp.sv | 27 ++
 rtl/guess_controller.sv | 125 ++++++++++++
 tb/tb_guess_controller.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/guess_pkg.sv
// Shared types for the number-guessing controller: result codes and FSM states.
package guess_pkg;

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_LOW   = 2'd1,
        RES_HIGH  = 2'd2,
        RES_MATCH = 2'd3
    } result_t;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ARM        = 3'd1,
        S_WAIT_GUESS = 3'd2,
        S_COMPARE    = 3'd3,
        S_WIN        = 3'd4,
        S_LOSE       = 3'd5
    } state_t;

endpackage

// File: rtl/guess_cmp.sv
// Combinational guess/target comparator producing the result code.
// Define GUESS_HINT_EN to report LOW/HIGH; otherwise only MATCH is distinguishable.
module guess_cmp
    import guess_pkg::*;
#(
    parameter int unsigned WIDTH = 7
) (
    input  logic [WIDTH-1:0] guess,
    input  logic [WIDTH-1:0] target,
    output result_t          result_c
);

    always_comb begin
        result_c = RES_NONE;
        if (guess == target) begin
            result_c = RES_MATCH;
        end
`ifdef GUESS_HINT_EN
        else if (guess < target) begin
            result_c = RES_LOW;
        end else begin
            result_c = RES_HIGH;
        end
`endif
    end

endmodule

// File: rtl/guess_controller.sv
// Round controller for a number-guessing game fed by an external LFSR.
// Optional feature macro GUESS_HINT_EN (LOW/HIGH hints) is handled in guess_cmp.
module guess_controller
    import guess_pkg::*;
#(
    parameter int unsigned WIDTH     = 7,
    parameter int unsigned MAX_TRIES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] rnd_in,
    input  logic             guess_valid,
    input  logic [WIDTH-1:0] guess,
    output logic             guess_ready,
    output logic             result_valid,
    output logic [1:0]       result,
    output logic [3:0]       tries,
    output logic             win,
    output logic             lose,
    output logic [WIDTH-1:0] target_out
);

    localparam int unsigned TRY_W = 4;

    state_t             state_q, state_n;
    logic [WIDTH-1:0]   target_q, target_n;
    logic [WIDTH-1:0]   guess_q, guess_n;
    logic [TRY_W-1:0]   tries_q, tries_n;
    result_t            result_q, result_n;
    logic               rv_n;
    result_t            cmp_c;

    guess_cmp #(.WIDTH(WIDTH)) u_cmp (
        .guess    (guess_q),
        .target   (target_q),
        .result_c (cmp_c)
    );

    // Next-state and datapath updates; start always wins over a pending guess or compare.
    always_comb begin
        state_n  = state_q;
        target_n = target_q;
        guess_n  = guess_q;
        tries_n  = tries_q;
        result_n = result_q;
        rv_n     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_n  = S_ARM;
                    result_n = RES_NONE;
                end
            end
            S_ARM: begin
                // All-ones is the XNOR-LFSR lockup value; never use it as a target.
                target_n = (rnd_in == {WIDTH{1'b1}}) ? WIDTH'(0) : rnd_in;
                tries_n  = TRY_W'(0);
                state_n  = S_WAIT_GUESS;
            end
            S_WAIT_GUESS: begin
                if (start) begin
                    state_n = S_ARM;
                end else if (guess_valid) begin
                    guess_n = guess;
                    tries_n = tries_q + TRY_W'(1);
                    state_n = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (start) begin
                    state_n = S_ARM;
                end else begin
                    rv_n     = 1'b1;
                    result_n = cmp_c;
                    if (cmp_c == RES_MATCH) begin
                        state_n = S_WIN;
                    end else if (tries_q == TRY_W'(MAX_TRIES)) begin
                        state_n = S_LOSE;
                    end else begin
                        state_n = S_WAIT_GUESS;
                    end
                end
            end
            S_WIN, S_LOSE: begin
                if (start) begin
                    state_n  = S_ARM;
                    result_n = RES_NONE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State and output registers; level outputs follow the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            target_q     <= WIDTH'(0);
            guess_q      <= WIDTH'(0);
            tries_q      <= TRY_W'(0);
            result_q     <= RES_NONE;
            result_valid <= 1'b0;
            guess_ready  <= 1'b0;
            win          <= 1'b0;
            lose         <= 1'b0;
            target_out   <= WIDTH'(0);
        end else begin
            state_q      <= state_n;
            target_q     <= target_n;
            guess_q      <= guess_n;
            tries_q      <= tries_n;
            result_q     <= result_n;
            result_valid <= rv_n;
            guess_ready  <= (state_n == S_WAIT_GUESS);
            win          <= (state_n == S_WIN);
            lose         <= (state_n == S_LOSE);
            target_out   <= ((state_n == S_WIN) || (state_n == S_LOSE)) ? target_n : WIDTH'(0);
        end
    end

    assign result = result_q;
    assign tries  = tries_q;

endmodule

// File: tb/tb_guess_controller.sv
// Self-checking bench for guess_controller: directed table, corner sequences, random vs. model.
module tb_guess_controller;

    localparam int unsigned W  = 7;
    localparam int unsigned MT = 8;

`ifdef GUESS_HINT_EN
    localparam logic [1:0] C_LOW  = 2'd1;
    localparam logic [1:0] C_HIGH = 2'd2;
`else
    localparam logic [1:0] C_LOW  = 2'd0;
    localparam logic [1:0] C_HIGH = 2'd0;
`endif
    localparam logic [1:0] C_MATCH = 2'd3;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] rnd_in;
    logic         guess_valid;
    logic [W-1:0] guess;
    logic         guess_ready;
    logic         result_valid;
    logic [1:0]   result;
    logic [3:0]   tries;
    logic         win;
    logic         lose;
    logic [W-1:0] target_out;

    int n_tests = 0;
    int n_fail  = 0;

    guess_controller #(.WIDTH(W), .MAX_TRIES(MT)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rnd_in       (rnd_in),
        .guess_valid  (guess_valid),
        .guess        (guess),
        .guess_ready  (guess_ready),
        .result_valid (result_valid),
        .result       (result),
        .tries        (tries),
        .win          (win),
        .lose         (lose),
        .target_out   (target_out)
    );

    always #5 clk = ~clk;

    logic [16:0] dut_vec;
    assign dut_vec = {result_valid, result, tries, win, lose, guess_ready, target_out};

    // Game-level reference: what the player has seen so far in the round.
    bit           m_started, m_arming, m_pending, m_won, m_lost, m_rv;
    int unsigned  m_target, m_tries, m_guess;
    logic [1:0]   m_result;

    task automatic model_reset();
        m_started = 0; m_arming = 0; m_pending = 0; m_won = 0; m_lost = 0; m_rv = 0;
        m_target = 0; m_tries = 0; m_guess = 0; m_result = 2'd0;
    endtask

    function automatic logic [1:0] score(int unsigned g, int unsigned t);
        if (g == t) return C_MATCH;
        if (g < t)  return C_LOW;
        return C_HIGH;
    endfunction

    task automatic model_step(input bit s, input int unsigned r, input bit gv, input int unsigned g);
        m_rv = 0;
        if (m_arming) begin
            m_target  = (r == (1 << W) - 1) ? 0 : r;
            m_tries   = 0;
            m_arming  = 0;
        end else if (s) begin
            if (m_won || m_lost || !m_started) m_result = 2'd0;
            m_arming = 1; m_pending = 0; m_won = 0; m_lost = 0; m_started = 1;
        end else if (m_pending) begin
            m_pending = 0;
            m_result  = score(m_guess, m_target);
            m_rv      = 1;
            if (m_result == C_MATCH) m_won = 1;
            else if (m_tries == MT)  m_lost = 1;
        end else if (m_started && !m_won && !m_lost && gv) begin
            m_guess   = g;
            m_tries   = m_tries + 1;
            m_pending = 1;
        end
    endtask

    function automatic logic [16:0] model_vec();
        bit rdy;
        rdy = m_started && !m_arming && !m_pending && !m_won && !m_lost;
        return {m_rv, m_result, 4'(m_tries), m_won, m_lost, rdy,
                (m_won || m_lost) ? W'(m_target) : W'(0)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, sample #1 after the edge and compare.
    task automatic tick(input bit s, input logic [W-1:0] r, input bit gv, input logic [W-1:0] g);
        start = s; rnd_in = r; guess_valid = gv; guess = g;
        @(posedge clk);
        model_step(s, r, gv, g);
        #1;
        chk("model", 32'(dut_vec), 32'(model_vec()));
    endtask

    task automatic new_round(input logic [W-1:0] r);
        tick(1'b1, r, 1'b0, W'(0));
        tick(1'b0, r, 1'b0, W'(0));
    endtask

    task automatic play(input logic [W-1:0] g);
        tick(1'b0, W'(0), 1'b1, g);
        tick(1'b0, W'(0), 1'b0, W'(0));
    endtask

    typedef struct {
        logic         s;
        logic [W-1:0] r;
        logic         gv;
        logic [W-1:0] g;
        logic         rv;
        logic [1:0]   res;
        logic [3:0]   tr;
        logic         w;
        logic         rdy;
        logic [W-1:0] tout;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{1'b1, 7'd42, 1'b0, 7'd0,  1'b0, 2'd0,    4'd0, 1'b0, 1'b0, 7'd0};
        tbl[1] = '{1'b0, 7'd42, 1'b0, 7'd0,  1'b0, 2'd0,    4'd0, 1'b0, 1'b1, 7'd0};
        tbl[2] = '{1'b0, 7'd0,  1'b1, 7'd10, 1'b0, 2'd0,    4'd1, 1'b0, 1'b0, 7'd0};
        tbl[3] = '{1'b0, 7'd0,  1'b0, 7'd0,  1'b1, C_LOW,   4'd1, 1'b0, 1'b1, 7'd0};
        tbl[4] = '{1'b0, 7'd0,  1'b1, 7'd90, 1'b0, C_LOW,   4'd2, 1'b0, 1'b0, 7'd0};
        tbl[5] = '{1'b0, 7'd0,  1'b0, 7'd0,  1'b1, C_HIGH,  4'd2, 1'b0, 1'b1, 7'd0};
        tbl[6] = '{1'b0, 7'd0,  1'b1, 7'd42, 1'b0, C_HIGH,  4'd3, 1'b0, 1'b0, 7'd0};
        tbl[7] = '{1'b0, 7'd0,  1'b0, 7'd0,  1'b1, C_MATCH, 4'd3, 1'b1, 1'b0, 7'd42};
        tbl[8] = '{1'b0, 7'd0,  1'b0, 7'd0,  1'b0, C_MATCH, 4'd3, 1'b1, 1'b0, 7'd42};

        reset = 1'b1; start = 1'b0; rnd_in = '0; guess_valid = 1'b0; guess = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 32'(dut_vec), 32'(0));
        reset = 1'b0;

        // Normal win from the directed table.
        for (int i = 0; i < 9; i++) begin
            tick(tbl[i].s, tbl[i].r, tbl[i].gv, tbl[i].g);
            chk($sformatf("table[%0d]", i), 32'(dut_vec),
                32'({tbl[i].rv, tbl[i].res, tbl[i].tr, tbl[i].w, 1'b0, tbl[i].rdy, tbl[i].tout}));
        end

        // Exhaust all tries.
        new_round(W'(5));
        for (int i = 0; i < int'(MT); i++) begin
            play(W'(6));
            chk("loss_result", 32'({result_valid, result}), 32'({1'b1, C_HIGH}));
        end
        chk("loss_lose", 32'(lose), 32'(1));
        chk("loss_tries", 32'(tries), 32'(MT));
        chk("loss_ready", 32'(guess_ready), 32'(0));
        tick(1'b0, W'(0), 1'b1, W'(5));
        chk("lose_ignores_guess", 32'({tries, win, lose}), 32'({4'(MT), 1'b0, 1'b1}));

        // Correct guess on the final try wins.
        new_round(W'(5));
        for (int i = 0; i < int'(MT) - 1; i++) play((i % 2 == 1) ? W'(4) : W'(6));
        play(W'(5));
        chk("lasttry_win", 32'({win, lose, tries}), 32'({1'b1, 1'b0, 4'(MT)}));

        // Lockup value becomes target 0.
        new_round(W'(127));
        play(W'(0));
        chk("lockup_win", 32'(win), 32'(1));
        chk("lockup_target_out", 32'(target_out), 32'(0));

        // Start beats a simultaneous guess in WAIT_GUESS.
        new_round(W'(20));
        tick(1'b1, W'(33), 1'b1, W'(20));
        chk("abort_wait_rv", 32'({result_valid, guess_ready}), 32'(0));
        tick(1'b0, W'(33), 1'b0, W'(0));
        chk("abort_wait_tries", 32'({tries, guess_ready}), 32'({4'd0, 1'b1}));
        play(W'(20));
        chk("abort_old_target", 32'(win), 32'(0));
        play(W'(33));
        chk("abort_new_target", 32'({win, target_out}), 32'({1'b1, 7'd33}));

        // Start during COMPARE suppresses the result pulse.
        new_round(W'(9));
        tick(1'b0, W'(0), 1'b1, W'(9));
        tick(1'b1, W'(11), 1'b0, W'(0));
        chk("abort_cmp_rv", 32'({result_valid, win}), 32'(0));
        tick(1'b0, W'(11), 1'b0, W'(0));
        play(W'(11));
        chk("abort_cmp_new", 32'(win), 32'(1));

        // Asynchronous reset while in COMPARE.
        new_round(W'(50));
        tick(1'b0, W'(0), 1'b1, W'(3));
        reset = 1'b1;
        #1;
        chk("async_reset_now", 32'(dut_vec), 32'(0));
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("async_reset_no_rv", 32'(result_valid), 32'(0));
        end
        reset = 1'b0;
        model_reset();

        // Randomized play against the reference model.
        for (int n = 0; n < 3000; n++) begin
            logic         s, gv;
            logic [W-1:0] r, g;
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                #1;
                chk("rand_reset", 32'(dut_vec), 32'(0));
                model_reset();
                @(posedge clk);
                #1;
                reset = 1'b0;
            end else begin
                s  = ($urandom_range(0, 19) == 0);
                gv = ($urandom_range(0, 1) == 1);
                r  = ($urandom_range(0, 9) == 0) ? W'(127) : W'($urandom);
                g  = ($urandom_range(0, 3) == 0) ? W'(m_target) : W'($urandom);
                tick(s, r, gv, g);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
